// File: rtl/plaintext_validator.sv
// Snoops RAM-A writes from the RC4 decrypt stage and grades each candidate key:
// every byte must be a lowercase letter or space, written in strict address order.
module plaintext_validator #(
    parameter int                   RAM_WIDTH          = 8,
    parameter int                   KEY_LENGTH         = 3,
    parameter int                   MESSAGE_LOG_LENGTH = 5,
    parameter int                   MESSAGE_LENGTH     = 32,
    parameter logic [RAM_WIDTH-1:0] LOW_CHAR           = 8'h61,
    parameter logic [RAM_WIDTH-1:0] HIGH_CHAR          = 8'h7A,
    parameter logic [RAM_WIDTH-1:0] SPACE_CHAR         = 8'h20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key_in,
    input  logic                             aWren,
    input  logic [MESSAGE_LOG_LENGTH-1:0]    aAddr,
    input  logic [RAM_WIDTH-1:0]             aIn,
    input  logic                             clear_found,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             fail,
    output logic [MESSAGE_LOG_LENGTH:0]      byte_count,
    output logic                             found,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]  found_key
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] PASS  = 2'd2;
    localparam logic [1:0] FAIL  = 2'd3;

    localparam logic [MESSAGE_LOG_LENGTH:0] LAST_INDEX =
        (MESSAGE_LOG_LENGTH + 1)'(MESSAGE_LENGTH - 1);

    logic [1:0]                        state;
    logic [KEY_LENGTH*RAM_WIDTH-1:0]   cur_key;
    logic                              char_ok;
    logic                              addr_ok;

    always_comb begin
        char_ok = ((aIn >= LOW_CHAR) && (aIn <= HIGH_CHAR)) || (aIn == SPACE_CHAR);
        addr_ok = (aAddr == byte_count[MESSAGE_LOG_LENGTH-1:0]);
    end

    assign busy = (state == CHECK);

    // start always takes priority; a clear_found in the same cycle as a pass
    // is overridden by the pass, which then records the current key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cur_key    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            byte_count <= '0;
            found      <= 1'b0;
            found_key  <= '0;
        end else begin
            done <= 1'b0;
            if (clear_found) begin
                found     <= 1'b0;
                found_key <= '0;
            end
            if (start) begin
                state      <= CHECK;
                byte_count <= '0;
                cur_key    <= key_in;
                pass       <= 1'b0;
                fail       <= 1'b0;
            end else if ((state == CHECK) && aWren) begin
                if (!char_ok || !addr_ok) begin
                    state <= FAIL;
                    fail  <= 1'b1;
                    done  <= 1'b1;
                end else if (byte_count == LAST_INDEX) begin
                    state      <= PASS;
                    pass       <= 1'b1;
                    done       <= 1'b1;
                    byte_count <= byte_count + 1'b1;
                    if (!found || clear_found) begin
                        found     <= 1'b1;
                        found_key <= cur_key;
                    end
                end else begin
                    byte_count <= byte_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_plaintext_validator.sv
// Directed-vector bench for plaintext_validator: pass/fail verdicts, character
// boundaries, address ordering, found-key latching, restart and async reset.
module tb_plaintext_validator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] key_in;
    logic        aWren;
    logic [4:0]  aAddr;
    logic [7:0]  aIn;
    logic        clear_found;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [5:0]  byte_count;
    logic        found;
    logic [23:0] found_key;

    int checks = 0;
    int failures = 0;
    logic [7:0] msg [32];

    plaintext_validator dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key_in      (key_in),
        .aWren       (aWren),
        .aAddr       (aAddr),
        .aIn         (aIn),
        .clear_found (clear_found),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .byte_count  (byte_count),
        .found       (found),
        .found_key   (found_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic startKey(input logic [23:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] data);
        aWren = 1'b1;
        aAddr = addr;
        aIn   = data;
        @(negedge clk);
        aWren = 1'b0;
    endtask

    task automatic sendMessage(input logic clearOnLast);
        for (int i = 0; i < 31; i++) applyStimulus(5'(i), msg[i]);
        clear_found = clearOnLast;
        applyStimulus(5'd31, msg[31]);
        clear_found = 1'b0;
    endtask

    initial begin
        string hello;
        logic [7:0] bvals [6];
        logic       bok   [6];
        hello = "hello world";
        for (int i = 0; i < 32; i++) msg[i] = (i < 11) ? hello[i] : 8'h61;
        bvals = '{8'h60, 8'h7B, 8'h1F, 8'h61, 8'h7A, 8'h20};
        bok   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset = 1'b0; start = 1'b0; key_in = '0; aWren = 1'b0;
        aAddr = '0; aIn = '0; clear_found = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_fail", fail, 0);
        checkOutput("rst_count", byte_count, 0);
        checkOutput("rst_found", found, 0);
        checkOutput("rst_key", found_key, 0);
        reset = 1'b1;
        @(negedge clk);

        // Valid message
        startKey(24'h000A1B);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_count", byte_count, 0);
        for (int i = 0; i < 31; i++) applyStimulus(5'(i), msg[i]);
        checkOutput("pre_last_count", byte_count, 31);
        checkOutput("pre_last_done", done, 0);
        applyStimulus(5'd31, msg[31]);
        checkOutput("v_done", done, 1);
        checkOutput("v_pass", pass, 1);
        checkOutput("v_fail", fail, 0);
        checkOutput("v_busy", busy, 0);
        checkOutput("v_count", byte_count, 32);
        checkOutput("v_found", found, 1);
        checkOutput("v_key", found_key, 24'h000A1B);
        @(negedge clk);
        checkOutput("v_done_width", done, 0);
        checkOutput("v_pass_held", pass, 1);
        applyStimulus(5'd0, 8'h41);
        checkOutput("pass_ignore_fail", fail, 0);
        checkOutput("pass_ignore_count", byte_count, 32);

        // Early fail
        startKey(24'h000001);
        checkOutput("new_start_pass", pass, 0);
        applyStimulus(5'd0, 8'h61);
        applyStimulus(5'd1, 8'h62);
        applyStimulus(5'd2, 8'h41);
        checkOutput("ef_fail", fail, 1);
        checkOutput("ef_done", done, 1);
        checkOutput("ef_pass", pass, 0);
        checkOutput("ef_count", byte_count, 2);
        applyStimulus(5'd2, 8'h61);
        checkOutput("ef_ignore_done", done, 0);
        checkOutput("ef_ignore_count", byte_count, 2);
        checkOutput("ef_ignore_fail", fail, 1);

        // Character boundaries
        for (int i = 0; i < 6; i++) begin
            startKey(24'h000005);
            applyStimulus(5'd0, bvals[i]);
            checkOutput($sformatf("bnd_%0h_fail", bvals[i]), fail, !bok[i]);
            checkOutput($sformatf("bnd_%0h_count", bvals[i]), byte_count, bok[i] ? 1 : 0);
        end

        // Address skip
        startKey(24'h000006);
        applyStimulus(5'd0, 8'h61);
        applyStimulus(5'd1, 8'h61);
        applyStimulus(5'd3, 8'h61);
        checkOutput("skip_fail", fail, 1);
        checkOutput("skip_done", done, 1);
        checkOutput("skip_count", byte_count, 2);

        // Second pass keeps first key; clear then pass records new key
        startKey(24'h000A1C);
        sendMessage(1'b0);
        checkOutput("p2_pass", pass, 1);
        checkOutput("p2_key", found_key, 24'h000A1B);
        clear_found = 1'b1;
        @(negedge clk);
        clear_found = 1'b0;
        checkOutput("clr_found", found, 0);
        checkOutput("clr_key", found_key, 0);
        startKey(24'h000A1C);
        sendMessage(1'b0);
        checkOutput("p3_found", found, 1);
        checkOutput("p3_key", found_key, 24'h000A1C);
        startKey(24'h000A1D);
        sendMessage(1'b1);
        checkOutput("clr_pass_found", found, 1);
        checkOutput("clr_pass_key", found_key, 24'h000A1D);

        // Restart mid-message; start beats a same-cycle write
        startKey(24'h111111);
        for (int i = 0; i < 10; i++) applyStimulus(5'(i), msg[i]);
        checkOutput("rs_pre_count", byte_count, 10);
        start = 1'b1; key_in = 24'h222222;
        aWren = 1'b1; aAddr = 5'd10; aIn = 8'h61;
        @(negedge clk);
        start = 1'b0; aWren = 1'b0;
        checkOutput("rs_count", byte_count, 0);
        checkOutput("rs_done", done, 0);
        checkOutput("rs_busy", busy, 1);
        applyStimulus(5'd0, 8'h61);
        checkOutput("rs_first_byte", byte_count, 1);
        checkOutput("rs_no_fail", fail, 0);

        // Asynchronous reset mid-CHECK
        applyStimulus(5'd1, 8'h61);
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_count", byte_count, 0);
        checkOutput("ar_found", found, 0);
        checkOutput("ar_key", found_key, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("ar_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
